// File: rtl/max10adc_sequencer.sv
// -----------------------------------------------------------------------------
// max10adc_sequencer
//
// Round-robin scan controller for the MAX10 modular ADC IP. It drives the IP's
// Avalon-ST command stream, keeps exactly one command outstanding, matches each
// response to its command by channel number and publishes one zero-extended
// 16-bit result register per scanned slot, with a one-cycle update strobe.
// A response that does not arrive within TIMEOUT cycles is declared lost: the
// sticky timeout_err flag is set and the scan moves on to the next slot.
//
// Optional build macro: MAX10ADC_SEQ_AVG_EN
//   When defined, every slot visit issues 2**AVG_LOG2 commands on the same
//   channel and the published result is the mean of the returned samples.
//   When undefined, one sample is taken per visit and AVG_LOG2 is ignored.
//
// Ports
//   clk, reset_n        system clock (ADC sys_clk), async active-low reset
//   enable              scan enable; an in-flight visit always completes
//   ch_mask[NUM_CH]     per-slot enable, sampled only when choosing a slot
//   cmd_valid/_channel/_sop/_eop, cmd_ready   command stream to the ADC IP
//   rsp_valid/_channel/_data                  response stream from the ADC IP
//   adc_data[16*NUM_CH] result registers, slot i at [16i+15:16i]
//   sample_strobe       one-cycle pulse on bit i when slot i is updated
//   busy                high whenever the FSM is not idle
//   timeout_err         sticky lost-response flag, cleared by clear_err
// -----------------------------------------------------------------------------
module max10adc_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int FIRST_CH = 1,
  parameter int TIMEOUT  = 1023,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic                  cmd_valid,
  output logic [4:0]            cmd_channel,
  output logic                  cmd_sop,
  output logic                  cmd_eop,
  input  logic                  cmd_ready,
  input  logic                  rsp_valid,
  input  logic [4:0]            rsp_channel,
  input  logic [11:0]           rsp_data,
  output logic [16*NUM_CH-1:0]  adc_data,
  output logic [NUM_CH-1:0]     sample_strobe,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  clear_err
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;

  // Pointer resets to the last slot so the first search lands on slot 0.
  localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_CH - 1);
  localparam logic [4:0]       CH_BASE  = 5'(FIRST_CH);
  // WAIT lasts at most TIMEOUT cycles: counts 0..TIMEOUT-1.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [4:0]        cmd_channel_q, cmd_channel_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_q, err_d;
  logic [NUM_CH-1:0] strobe_q, strobe_d;

  logic              rsp_match;
  logic              tmr_done;
  logic              store_en;
  logic              timeout_hit;
  logic [11:0]       store_val;
  logic [PTR_W-1:0]  next_ptr;

`ifdef MAX10ADC_SEQ_AVG_EN
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_sum;
  logic             last_sample;

  assign acc_sum     = acc_q + ACC_W'(rsp_data);
  assign last_sample = (cnt_q == CNT_LAST);
  // Top 12 bits of the sum are the mean (sum >> AVG_LOG2).
  assign store_val   = acc_sum[ACC_W-1:AVG_LOG2];
`else
  assign store_val   = rsp_data;
`endif

  // Next enabled slot strictly after cur, wrapping; a lone enabled slot
  // selects itself because the search covers a full turn (k = NUM_CH).
  // Iterating k downwards lets the nearest candidate overwrite the others.
  function automatic logic [PTR_W-1:0] next_slot(
    input logic [PTR_W-1:0]  cur,
    input logic [NUM_CH-1:0] mask
  );
    logic [PTR_W-1:0] pick;
    int               idx;
    pick = cur;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_CH;
      if (mask[PTR_W'(idx)]) pick = PTR_W'(idx);
    end
    return pick;
  endfunction

  assign next_ptr  = next_slot(ptr_q, ch_mask);
  assign rsp_match = rsp_valid && (rsp_channel == cmd_channel_q);
  assign tmr_done  = (tmr_q == TMR_LAST);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cmd_channel_d = cmd_channel_q;
    tmr_d         = tmr_q;
    err_d         = err_q;
    store_en      = 1'b0;
    timeout_hit   = 1'b0;
`ifdef MAX10ADC_SEQ_AVG_EN
    acc_d         = acc_q;
    cnt_d         = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable && (ch_mask != '0)) state_d = S_SELECT;
      end

      S_SELECT: begin
        if (ch_mask == '0) begin
          state_d = S_IDLE;
        end else begin
          ptr_d         = next_ptr;
          cmd_channel_d = CH_BASE + 5'(next_ptr);
          state_d       = S_ISSUE;
`ifdef MAX10ADC_SEQ_AVG_EN
          acc_d         = '0;
          cnt_d         = '0;
`endif
        end
      end

      // Command is held until accepted, whatever enable/ch_mask do meanwhile.
      S_ISSUE: begin
        if (cmd_ready) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        tmr_d = tmr_q + 1'b1;
        // A match in the terminal-count cycle takes priority over the timeout.
        if (rsp_match) begin
`ifdef MAX10ADC_SEQ_AVG_EN
          if (last_sample) begin
            store_en = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_STORE;
          end else begin
            // Mid-visit: keep sampling the same channel regardless of enable.
            acc_d    = acc_sum;
            cnt_d    = cnt_q + 1'b1;
            state_d  = S_ISSUE;
          end
`else
          store_en = 1'b1;
          state_d  = S_STORE;
`endif
        end else if (tmr_done) begin
          timeout_hit = 1'b1;
          state_d     = enable ? S_SELECT : S_IDLE;
`ifdef MAX10ADC_SEQ_AVG_EN
          acc_d       = '0;
          cnt_d       = '0;
`endif
        end
      end

      S_STORE: begin
        state_d = enable ? S_SELECT : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Set wins over a simultaneous clear.
    if (clear_err)   err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  // Result registers and strobes are loaded on the WAIT->STORE edge, so the
  // new value and its strobe are both visible during the STORE cycle.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    logic        hit;
    logic [11:0] res_q, res_d;

    assign hit           = store_en && (ptr_q == PTR_W'(gi));
    assign res_d         = hit ? store_val : res_q;
    assign strobe_d[gi]  = hit;
    assign adc_data[16*gi +: 16] = {4'b0000, res_q};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) res_q <= '0;
      else          res_q <= res_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_RST;
      cmd_channel_q <= CH_BASE;
      tmr_q         <= '0;
      err_q         <= 1'b0;
      strobe_q      <= '0;
`ifdef MAX10ADC_SEQ_AVG_EN
      acc_q         <= '0;
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cmd_channel_q <= cmd_channel_d;
      tmr_q         <= tmr_d;
      err_q         <= err_d;
      strobe_q      <= strobe_d;
`ifdef MAX10ADC_SEQ_AVG_EN
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign cmd_valid     = (state_q == S_ISSUE);
  assign cmd_sop       = cmd_valid;
  assign cmd_eop       = cmd_valid;
  assign cmd_channel   = cmd_channel_q;
  assign sample_strobe = strobe_q;
  assign busy          = (state_q != S_IDLE);
  assign timeout_err   = err_q;

endmodule
